// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: scoreboard slot layout,
// forwarding-select encoding and the zero-register index.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WR  = 2'b10
   } fwd_sel_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       reg_wr;
      logic       load;
      logic       set_flags;
   } slot_t;

   localparam logic [4:0] XZR        = 5'd31;
   localparam slot_t      EMPTY_SLOT = '0;

endpackage

// File: rtl/pipe_slot.sv
// One scoreboard slot: holds the writer record of the instruction in a stage
// and reports whether it will write either of two queried registers.
module pipe_slot
   import pipe_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       bubble,
   input  slot_t      d,
   input  logic [4:0] r_a,
   input  logic [4:0] r_b,
   output slot_t      q,
   output logic       match_a,
   output logic       match_b
);

   always_ff @(posedge clk) begin
      if (rst || bubble)
         q <= EMPTY_SLOT;
      else
         q <= d;
   end

   // XZR reads always return zero, so a write to it can never be a hazard.
   assign match_a = q.valid & q.reg_wr & (q.rd == r_a) & (r_a != XZR);
   assign match_b = q.valid & q.reg_wr & (q.rd == r_b) & (r_b != XZR);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for the 5-stage pipeline: stalls, IF squash on accelerated
// branches, registered ALU forwarding selects and the live-flag select.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             dec_valid,
   input  logic [4:0]       dec_Rn,
   input  logic [4:0]       dec_Ab,
   input  logic             dec_use_Rn,
   input  logic             dec_use_Ab,
   input  logic [4:0]       dec_Rd,
   input  logic             dec_reg_wr,
   input  logic             dec_load,
   input  logic             dec_cbz,
   input  logic             dec_bcond,
   input  logic             dec_set_flags,
   input  logic             br_taken,
   output logic             stall,
   output logic             flush_if,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             flag_live,
   output logic [CNT_W-1:0] stall_cycles
);

   slot_t    dec_slot, ex_q, mem_q, wr_q;
   logic     ex_bubble;
   logic     ex_rn, ex_ab, mem_rn, mem_ab, wr_rn, wr_ab;
   logic     load_use, cbz_hazard;
   fwd_sel_t fwd_a_d, fwd_b_d, fwd_a_q, fwd_b_q;

   assign dec_slot = '{valid: dec_valid, rd: dec_Rd, reg_wr: dec_reg_wr,
                       load: dec_load, set_flags: dec_set_flags};

   pipe_slot u_ex (
      .clk(clk), .rst(rst), .bubble(ex_bubble), .d(dec_slot),
      .r_a(dec_Rn), .r_b(dec_Ab), .q(ex_q), .match_a(ex_rn), .match_b(ex_ab)
   );

   pipe_slot u_mem (
      .clk(clk), .rst(rst), .bubble(1'b0), .d(ex_q),
      .r_a(dec_Rn), .r_b(dec_Ab), .q(mem_q), .match_a(mem_rn), .match_b(mem_ab)
   );

   // WR data is written back before REG/DEC reads, so this slot only tracks
   // occupancy and never feeds a hazard decision.
   pipe_slot u_wr (
      .clk(clk), .rst(rst), .bubble(1'b0), .d(mem_q),
      .r_a(dec_Rn), .r_b(dec_Ab), .q(wr_q), .match_a(wr_rn), .match_b(wr_ab)
   );

   // CBZ compares Rn in REG/DEC, so it must wait until the producer leaves MEM.
   always_comb begin
      load_use   = ex_q.load & ((dec_use_Rn & ex_rn) | (dec_use_Ab & ex_ab));
      cbz_hazard = dec_cbz & (ex_rn | mem_rn);
      stall      = dec_valid & (load_use | cbz_hazard);
      flush_if   = br_taken & dec_valid & ~stall;
      ex_bubble  = stall | flush_if | ~dec_valid;
      flag_live  = dec_bcond & ex_q.valid & ex_q.set_flags;

      fwd_a_d = FWD_REG;
      fwd_b_d = FWD_REG;
      if (!ex_bubble) begin
         if (ex_rn)       fwd_a_d = FWD_MEM;
         else if (mem_rn) fwd_a_d = FWD_WR;
         if (ex_ab)       fwd_b_d = FWD_MEM;
         else if (mem_ab) fwd_b_d = FWD_WR;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fwd_a_q      <= FWD_REG;
         fwd_b_q      <= FWD_REG;
         stall_cycles <= '0;
      end else begin
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
         if (stall && (stall_cycles != {CNT_W{1'b1}}))
            stall_cycles <= stall_cycles + 1'b1;
      end
   end

   assign fwd_a = fwd_a_q;
   assign fwd_b = fwd_b_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed instruction sequences plus random
// traffic, checked against an instruction-history reference model.
module tb_pipeline_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        dec_valid, dec_use_Rn, dec_use_Ab, dec_reg_wr, dec_load;
   logic        dec_cbz, dec_bcond, dec_set_flags, br_taken;
   logic [4:0]  dec_Rn, dec_Ab, dec_Rd;
   logic        stall, flush_if, flag_live;
   logic [1:0]  fwd_a, fwd_b;
   logic [31:0] stall_cycles;

   pipeline_hazard_ctrl #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_Rn(dec_Rn), .dec_Ab(dec_Ab),
      .dec_use_Rn(dec_use_Rn), .dec_use_Ab(dec_use_Ab), .dec_Rd(dec_Rd),
      .dec_reg_wr(dec_reg_wr), .dec_load(dec_load), .dec_cbz(dec_cbz),
      .dec_bcond(dec_bcond), .dec_set_flags(dec_set_flags), .br_taken(br_taken),
      .stall(stall), .flush_if(flush_if), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .flag_live(flag_live), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       valid;
      bit [4:0] rn, ab, rd;
      bit       use_rn, use_ab, wr, load, cbz, bcond, sf, taken;
   } instr_t;

   typedef struct {
      bit       valid;
      bit [4:0] rd;
      bit       wr, load, sf;
   } rec_t;

   // hist[k] is the instruction that entered EX at edge k; age 0 = EX, 1 = MEM.
   rec_t        hist[int];
   int          n_edges = 0;
   int          last_reset = 0;
   bit [1:0]    m_fwd_a = 2'b00, m_fwd_b = 2'b00;
   bit [31:0]   m_cnt = 0;
   int          compared = 0, mismatched = 0;

   function automatic rec_t inFlight(input int age);
      rec_t r;
      int   k;
      r = '{default: 0};
      k = n_edges - age;
      if (k > last_reset && hist.exists(k)) r = hist[k];
      return r;
   endfunction

   function automatic bit writes(input int age, input bit [4:0] r);
      rec_t p;
      p = inFlight(age);
      return p.valid && p.wr && (p.rd == r) && (r != 5'd31);
   endfunction

   function automatic bit expStall();
      bit lu, cb;
      if (!dec_valid) return 1'b0;
      lu = inFlight(0).load && ((dec_use_Rn && writes(0, dec_Rn)) || (dec_use_Ab && writes(0, dec_Ab)));
      cb = dec_cbz && (writes(0, dec_Rn) || writes(1, dec_Rn));
      return lu || cb;
   endfunction

   function automatic bit [1:0] srcFor(input bit [4:0] r);
      if (writes(0, r)) return 2'b01;
      if (writes(1, r)) return 2'b10;
      return 2'b00;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic applyStimulus(input instr_t i);
      dec_valid     = i.valid;
      dec_Rn        = i.rn;
      dec_Ab        = i.ab;
      dec_use_Rn    = i.use_rn;
      dec_use_Ab    = i.use_ab;
      dec_Rd        = i.rd;
      dec_reg_wr    = i.wr;
      dec_load      = i.load;
      dec_cbz       = i.cbz;
      dec_bcond     = i.bcond;
      dec_set_flags = i.sf;
      br_taken      = i.taken;
   endtask

   // Checks one cycle's outputs, then advances the model across the clock edge.
   task automatic runCycle(output bit es);
      bit       ef, el, bub;
      bit [1:0] na, nb;
      rec_t     e;
      #1;
      es  = expStall();
      ef  = br_taken && dec_valid && !es;
      el  = dec_bcond && inFlight(0).valid && inFlight(0).sf;
      checkOutput("stall", 32'(stall), 32'(es));
      checkOutput("flush_if", 32'(flush_if), 32'(ef));
      checkOutput("flag_live", 32'(flag_live), 32'(el));
      checkOutput("fwd_a", 32'(fwd_a), 32'(m_fwd_a));
      checkOutput("fwd_b", 32'(fwd_b), 32'(m_fwd_b));
      checkOutput("stall_cycles", stall_cycles, m_cnt);
      bub = es || ef || !dec_valid;
      na  = bub ? 2'b00 : srcFor(dec_Rn);
      nb  = bub ? 2'b00 : srcFor(dec_Ab);
      e   = '{valid: !bub, rd: dec_Rd, wr: dec_reg_wr, load: dec_load, sf: dec_set_flags};
      @(posedge clk);
      n_edges++;
      if (rst) begin
         last_reset = n_edges;
         m_fwd_a = 2'b00;
         m_fwd_b = 2'b00;
         m_cnt   = 0;
      end else begin
         hist[n_edges] = e;
         m_fwd_a = na;
         m_fwd_b = nb;
         if (es && m_cnt != 32'hFFFF_FFFF) m_cnt++;
      end
      #1;
   endtask

   // Presents an instruction and holds it while stalled; returns stall count.
   task automatic issue(input instr_t i, output int nst);
      bit s;
      nst = 0;
      applyStimulus(i);
      for (int k = 0; k < 6; k++) begin
         runCycle(s);
         if (!s) break;
         nst++;
      end
      if (s) checkOutput("stall_bound", 32'(s), 32'd0);
   endtask

   function automatic instr_t nop();
      instr_t i;
      i = '{default: 0};
      return i;
   endfunction

   function automatic instr_t alu(input bit [4:0] rd, input bit [4:0] rn, input bit [4:0] ab, input bit sf);
      instr_t i;
      i = '{default: 0};
      i.valid = 1; i.rd = rd; i.rn = rn; i.ab = ab; i.use_rn = 1; i.use_ab = 1; i.wr = 1; i.sf = sf;
      return i;
   endfunction

   function automatic instr_t ldur(input bit [4:0] rd, input bit [4:0] rn);
      instr_t i;
      i = '{default: 0};
      i.valid = 1; i.rd = rd; i.rn = rn; i.use_rn = 1; i.wr = 1; i.load = 1;
      return i;
   endfunction

   function automatic instr_t cbzI(input bit [4:0] rn, input bit taken);
      instr_t i;
      i = '{default: 0};
      i.valid = 1; i.rn = rn; i.use_rn = 1; i.cbz = 1; i.taken = taken;
      return i;
   endfunction

   function automatic instr_t bcondI(input bit taken);
      instr_t i;
      i = '{default: 0};
      i.valid = 1; i.bcond = 1; i.taken = taken;
      return i;
   endfunction

   task automatic doReset();
      bit s;
      rst = 1'b1;
      applyStimulus(nop());
      runCycle(s);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int     nst;
      bit     s, held;
      instr_t cur;
      bit [4:0] regs [4];
      regs[0] = 5'd1; regs[1] = 5'd2; regs[2] = 5'd3; regs[3] = 5'd31;

      rst = 1'b1;
      applyStimulus(nop());
      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput("reset_stall", 32'(stall), 32'd0);
      checkOutput("reset_flush", 32'(flush_if), 32'd0);
      checkOutput("reset_fwd_a", 32'(fwd_a), 32'd0);
      checkOutput("reset_fwd_b", 32'(fwd_b), 32'd0);
      checkOutput("reset_cnt", stall_cycles, 32'd0);
      rst = 1'b0;

      // ALU -> ALU forwards from MEM with no stall
      issue(alu(5'd1, 5'd2, 5'd3, 1'b1), nst);
      issue(alu(5'd2, 5'd1, 5'd3, 1'b0), nst);
      checkOutput("t1_stalls", 32'(nst), 32'd0);
      checkOutput("t1_fwd_a", 32'(fwd_a), 32'h1);

      // Load-use: one stall, then forward from WR
      doReset();
      issue(ldur(5'd4, 5'd0), nst);
      issue(alu(5'd5, 5'd4, 5'd6, 1'b0), nst);
      checkOutput("t2_stalls", 32'(nst), 32'd1);
      checkOutput("t2_fwd_a", 32'(fwd_a), 32'h2);
      checkOutput("t2_cnt", stall_cycles, 32'd1);

      // Producer two ahead forwards B from WR; XZR never forwards
      doReset();
      issue(alu(5'd7, 5'd1, 5'd2, 1'b0), nst);
      issue(nop(), nst);
      issue(alu(5'd8, 5'd9, 5'd7, 1'b0), nst);
      checkOutput("t3_fwd_b", 32'(fwd_b), 32'h2);
      issue(ldur(5'd31, 5'd0), nst);
      issue(alu(5'd10, 5'd31, 5'd31, 1'b0), nst);
      checkOutput("t3_xzr_stalls", 32'(nst), 32'd0);
      checkOutput("t3_xzr_fwd_a", 32'(fwd_a), 32'd0);
      checkOutput("t3_xzr_fwd_b", 32'(fwd_b), 32'd0);

      // SUBS then taken B.cond: live flags, one-cycle squash
      doReset();
      issue(alu(5'd1, 5'd2, 5'd3, 1'b1), nst);
      applyStimulus(bcondI(1'b1));
      #1;
      checkOutput("t4_flag_live", 32'(flag_live), 32'd1);
      checkOutput("t4_flush", 32'(flush_if), 32'd1);
      runCycle(s);
      applyStimulus(alu(5'd9, 5'd9, 5'd9, 1'b0));
      applyStimulus(nop());
      #1;
      checkOutput("t4_flush_gone", 32'(flush_if), 32'd0);
      runCycle(s);

      // ADD X3 then taken CBZ X3: two stalls, squash on the third cycle
      doReset();
      issue(alu(5'd3, 5'd1, 5'd2, 1'b0), nst);
      issue(cbzI(5'd3, 1'b1), nst);
      checkOutput("t5_stalls", 32'(nst), 32'd2);
      checkOutput("t5_cnt", stall_cycles, 32'd2);

      // Reset in the middle of a load-use stall
      doReset();
      issue(ldur(5'd4, 5'd0), nst);
      applyStimulus(alu(5'd5, 5'd4, 5'd6, 1'b0));
      rst = 1'b1;
      runCycle(s);
      rst = 1'b0;
      applyStimulus(alu(5'd5, 5'd4, 5'd6, 1'b0));
      #1;
      checkOutput("t6_stall", 32'(stall), 32'd0);
      checkOutput("t6_fwd_a", 32'(fwd_a), 32'd0);
      checkOutput("t6_fwd_b", 32'(fwd_b), 32'd0);
      checkOutput("t6_cnt", stall_cycles, 32'd0);
      runCycle(s);

      // Random traffic over a small register set to provoke frequent hazards
      doReset();
      held = 1'b0;
      cur  = nop();
      for (int n = 0; n < 600; n++) begin
         if (!held) begin
            cur.valid  = ($urandom_range(0, 7) != 0);
            cur.rn     = regs[$urandom_range(0, 3)];
            cur.ab     = regs[$urandom_range(0, 3)];
            cur.rd     = regs[$urandom_range(0, 3)];
            cur.use_rn = 1'($urandom);
            cur.use_ab = 1'($urandom);
            cur.wr     = 1'($urandom);
            cur.load   = ($urandom_range(0, 2) == 0);
            cur.cbz    = ($urandom_range(0, 5) == 0);
            cur.bcond  = ($urandom_range(0, 5) == 0);
            cur.sf     = 1'($urandom);
            cur.taken  = ($urandom_range(0, 3) == 0);
         end
         rst = ($urandom_range(0, 99) == 0);
         applyStimulus(cur);
         runCycle(s);
         held = s && !rst;
      end
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
